// File: rtl/jtag_dr_bank.sv
// JTAG instruction/data-register bank: IR, IDCODE, BYPASS, boundary-scan gating
// and NUM_USER parallel-load user data registers behind one TDO mux.
module jtag_dr_bank #(
    parameter int unsigned                 IR_LENGTH    = 4,
    parameter logic [31:0]                 IDCODE_VALUE = 32'h1A5B_C001,
    parameter logic [IR_LENGTH-1:0]        IR_CAPTURE   = IR_LENGTH'(4'b0101),
    parameter int unsigned                 NUM_USER     = 2,
    parameter int unsigned                 USER_WIDTH   = 8,
    parameter int unsigned                 USER_BASE    = 'hA
) (
    input  logic                           internal_clk,
    input  logic                           reg_trstn,
    input  logic                           reg_tck_enable,
    input  logic                           reg_test_logic_reset,
    input  logic                           reg_capture_ir,
    input  logic                           reg_shift_ir,
    input  logic                           reg_update_ir,
    input  logic                           reg_capture_dr,
    input  logic                           reg_shift_dr,
    input  logic                           reg_update_dr,
    input  logic                           reg_tdi,
    output logic                           reg_tdo,
    output logic [IR_LENGTH-1:0]           reg_ir_out,
    output logic                           reg_mode_bsc,
    output logic                           reg_capture_bsc,
    output logic                           reg_shift_bsc,
    output logic                           reg_update_bsc,
    output logic                           reg_scan_to_bsc,
    input  logic                           reg_scan_from_bsc,
    input  logic [NUM_USER*USER_WIDTH-1:0] user_dr_in,
    output logic [NUM_USER*USER_WIDTH-1:0] user_dr_out,
    output logic [NUM_USER-1:0]            user_update_pulse
);

    localparam logic [IR_LENGTH-1:0] OpIdcode = '0;
    localparam logic [IR_LENGTH-1:0] OpExtest = IR_LENGTH'(3);
    localparam logic [IR_LENGTH-1:0] OpSample = IR_LENGTH'(8);
    localparam int unsigned          MaxUserOp = (1 << IR_LENGTH) - 2;

    if (IDCODE_VALUE[0] != 1'b1) begin : g_bad_idcode
        $error("IDCODE_VALUE bit 0 must be 1");
    end
    if (IR_CAPTURE[1:0] != 2'b01) begin : g_bad_ir_capture
        $error("IR_CAPTURE[1:0] must be 2'b01");
    end
    for (genvar k = 0; k < NUM_USER; k++) begin : g_op_check
        if (USER_BASE + k == 0 || USER_BASE + k == 3 || USER_BASE + k == 8 ||
            USER_BASE + k > MaxUserOp) begin : g_bad_op
            $error("user opcode collides with a fixed opcode or is out of range");
        end
    end

    logic [IR_LENGTH-1:0]                 ir_sr_q, ir_sr_d, ir_hold_q, ir_hold_d;
    logic [31:0]                          idcode_q, idcode_d;
    logic                                 bypass_q, bypass_d;
    logic [NUM_USER-1:0][USER_WIDTH-1:0]  user_sr_q, user_sr_d;
    logic [NUM_USER*USER_WIDTH-1:0]       user_out_q, user_out_d;
    logic [NUM_USER-1:0]                  pulse_q, pulse_d;

    logic [NUM_USER-1:0] user_sel;
    logic                is_idcode, is_bsc, is_user, is_bypass;

    for (genvar k = 0; k < NUM_USER; k++) begin : g_user_sel
        assign user_sel[k] = (ir_hold_q == IR_LENGTH'(USER_BASE + k));
    end

    assign is_idcode = (ir_hold_q == OpIdcode);
    assign is_bsc    = (ir_hold_q == OpSample) || (ir_hold_q == OpExtest);
    assign is_user   = |user_sel;
    // Anything not otherwise decoded, including all-ones, behaves as BYPASS.
    assign is_bypass = !is_idcode && !is_bsc && !is_user;

    always_comb begin
        ir_sr_d    = ir_sr_q;
        ir_hold_d  = ir_hold_q;
        idcode_d   = idcode_q;
        bypass_d   = bypass_q;
        user_sr_d  = user_sr_q;
        user_out_d = user_out_q;
        pulse_d    = '0;
        if (reg_tck_enable) begin
            if (reg_test_logic_reset) begin
                ir_sr_d    = OpIdcode;
                ir_hold_d  = OpIdcode;
                idcode_d   = '0;
                bypass_d   = 1'b0;
                user_sr_d  = '0;
                user_out_d = '0;
            end else begin
                if (reg_capture_ir) begin
                    ir_sr_d = IR_CAPTURE;
                end else if (reg_shift_ir) begin
                    ir_sr_d = {reg_tdi, ir_sr_q[IR_LENGTH-1:1]};
                end else if (reg_update_ir) begin
                    ir_hold_d = ir_sr_q;
                end

                if (is_idcode) begin
                    if (reg_capture_dr)    idcode_d = IDCODE_VALUE;
                    else if (reg_shift_dr) idcode_d = {reg_tdi, idcode_q[31:1]};
                end

                if (is_bypass) begin
                    if (reg_capture_dr)    bypass_d = 1'b0;
                    else if (reg_shift_dr) bypass_d = reg_tdi;
                end

                for (int k = 0; k < NUM_USER; k++) begin
                    if (user_sel[k]) begin
                        if (reg_capture_dr) begin
                            user_sr_d[k] = user_dr_in[k*USER_WIDTH +: USER_WIDTH];
                        end else if (reg_shift_dr) begin
                            // Written as a shift so USER_WIDTH == 1 stays legal.
                            user_sr_d[k] = (user_sr_q[k] >> 1) |
                                           (USER_WIDTH'(reg_tdi) << (USER_WIDTH - 1));
                        end else if (reg_update_dr) begin
                            user_out_d[k*USER_WIDTH +: USER_WIDTH] = user_sr_q[k];
                            pulse_d[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge internal_clk or negedge reg_trstn) begin
        if (!reg_trstn) begin
            ir_sr_q    <= OpIdcode;
            ir_hold_q  <= OpIdcode;
            idcode_q   <= '0;
            bypass_q   <= 1'b0;
            user_sr_q  <= '0;
            user_out_q <= '0;
            pulse_q    <= '0;
        end else begin
            ir_sr_q    <= ir_sr_d;
            ir_hold_q  <= ir_hold_d;
            idcode_q   <= idcode_d;
            bypass_q   <= bypass_d;
            user_sr_q  <= user_sr_d;
            user_out_q <= user_out_d;
            pulse_q    <= pulse_d;
        end
    end

    always_comb begin
        reg_tdo = bypass_q;
        if (reg_shift_ir) begin
            reg_tdo = ir_sr_q[0];
        end else if (is_idcode) begin
            reg_tdo = idcode_q[0];
        end else if (is_bsc) begin
            reg_tdo = reg_scan_from_bsc;
        end else begin
            for (int k = 0; k < NUM_USER; k++) begin
                if (user_sel[k]) reg_tdo = user_sr_q[k][0];
            end
        end
    end

    assign reg_ir_out        = ir_hold_q;
    assign reg_mode_bsc      = (ir_hold_q == OpExtest);
    assign reg_capture_bsc   = is_bsc && reg_capture_dr;
    assign reg_shift_bsc     = is_bsc && reg_shift_dr;
    assign reg_update_bsc    = is_bsc && reg_update_dr;
    assign reg_scan_to_bsc   = is_bsc && reg_tdi;
    assign user_dr_out       = user_out_q;
    assign user_update_pulse = pulse_q;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Directed bench for jtag_dr_bank: opcode decode table plus hand-written
// IR/DR scan, update-pulse, TLR, async-reset and clock-enable sequences.
module tb_jtag_dr_bank;

    logic        internal_clk = 1'b0;
    logic        reg_trstn = 1'b0;
    logic        reg_tck_enable = 1'b1;
    logic        reg_test_logic_reset = 1'b0;
    logic        reg_capture_ir = 1'b0, reg_shift_ir = 1'b0, reg_update_ir = 1'b0;
    logic        reg_capture_dr = 1'b0, reg_shift_dr = 1'b0, reg_update_dr = 1'b0;
    logic        reg_tdi = 1'b0;
    logic        reg_tdo;
    logic [3:0]  reg_ir_out;
    logic        reg_mode_bsc, reg_capture_bsc, reg_shift_bsc, reg_update_bsc;
    logic        reg_scan_to_bsc;
    logic        reg_scan_from_bsc = 1'b1;
    logic [15:0] user_dr_in = 16'h813C;
    logic [15:0] user_dr_out;
    logic [1:0]  user_update_pulse;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [5:0] CIR = 6'b100000, SIR = 6'b010000, UIR = 6'b001000;
    localparam logic [5:0] CDR = 6'b000100, SDR = 6'b000010, UDR = 6'b000001;

    jtag_dr_bank dut (
        .internal_clk        (internal_clk),
        .reg_trstn           (reg_trstn),
        .reg_tck_enable      (reg_tck_enable),
        .reg_test_logic_reset(reg_test_logic_reset),
        .reg_capture_ir      (reg_capture_ir),
        .reg_shift_ir        (reg_shift_ir),
        .reg_update_ir       (reg_update_ir),
        .reg_capture_dr      (reg_capture_dr),
        .reg_shift_dr        (reg_shift_dr),
        .reg_update_dr       (reg_update_dr),
        .reg_tdi             (reg_tdi),
        .reg_tdo             (reg_tdo),
        .reg_ir_out          (reg_ir_out),
        .reg_mode_bsc        (reg_mode_bsc),
        .reg_capture_bsc     (reg_capture_bsc),
        .reg_shift_bsc       (reg_shift_bsc),
        .reg_update_bsc      (reg_update_bsc),
        .reg_scan_to_bsc     (reg_scan_to_bsc),
        .reg_scan_from_bsc   (reg_scan_from_bsc),
        .user_dr_in          (user_dr_in),
        .user_dr_out         (user_dr_out),
        .user_update_pulse   (user_update_pulse)
    );

    always #5 internal_clk = ~internal_clk;

    typedef struct {
        logic [3:0] op;
        logic       mode;   // expected reg_mode_bsc
        logic       gate;   // BSC controls follow the DR flags
        logic       tdo;    // tdo after capture_dr, before first shift
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] f, input logic tdi);
        {reg_capture_ir, reg_shift_ir, reg_update_ir,
         reg_capture_dr, reg_shift_dr, reg_update_dr} = f;
        reg_tdi = tdi;
        #1;
    endtask

    task automatic edge1();
        @(posedge internal_clk);
        #1;
    endtask

    task automatic load_ir(input logic [3:0] op);
        drive(CIR, 1'b0); edge1();
        for (int i = 0; i < 4; i++) begin
            drive(SIR, op[i]); edge1();
        end
        drive(UIR, 1'b0); edge1();
        drive(6'b0, 1'b0);
    endtask

    // Capture, shift in sh LSB first (collecting tdo), then update.
    task automatic user_scan(input logic [3:0] op, input logic [7:0] sh, output logic [7:0] got);
        load_ir(op);
        drive(CDR, 1'b0); edge1();
        for (int i = 0; i < 8; i++) begin
            drive(SDR, sh[i]);
            got[i] = reg_tdo;
            edge1();
        end
        drive(UDR, 1'b0); edge1();
        drive(6'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] word;
        logic [7:0]  got;

        tbl[0] = '{4'h0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{4'h3, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{4'h8, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{4'hF, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{4'h6, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{4'hA, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{4'hB, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{4'hC, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{4'h1, 1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_ir_out", 64'(reg_ir_out), 64'h0);
        chk("rst_user_out", 64'(user_dr_out), 64'h0);
        chk("rst_pulse", 64'(user_update_pulse), 64'h0);
        chk("rst_mode_bsc", 64'(reg_mode_bsc), 64'h0);
        reg_trstn = 1'b1;
        edge1();

        // IDCODE readout
        drive(CDR, 1'b0); edge1();
        for (int i = 0; i < 32; i++) begin
            drive(SDR, 1'b0);
            word[i] = reg_tdo;
            edge1();
        end
        drive(6'b0, 1'b0);
        chk("idcode_shift", 64'(word), 64'h1A5B_C001);
        chk("idcode_ir_out", 64'(reg_ir_out), 64'h0);

        // IR scan of all ones, then BYPASS delay
        drive(CIR, 1'b0); edge1();
        for (int i = 0; i < 4; i++) begin
            drive(SIR, 1'b1);
            word[i] = reg_tdo;
            edge1();
        end
        chk("ir_capture_out", 64'(word[3:0]), 64'h5);
        drive(UIR, 1'b0); edge1();
        drive(6'b0, 1'b0);
        chk("ir_hold_f", 64'(reg_ir_out), 64'hF);
        drive(CDR, 1'b0); edge1();
        word = '0;
        for (int i = 0; i < 4; i++) begin
            drive(SDR, (i == 1) ? 1'b0 : 1'b1);
            word[i] = reg_tdo;
            edge1();
        end
        drive(6'b0, 1'b0);
        word[4] = reg_tdo;
        chk("bypass_delay", 64'(word[4:0]), 64'h1A);

        // Opcode decode table
        for (int v = 0; v < 9; v++) begin
            load_ir(tbl[v].op);
            chk($sformatf("tbl%0d_ir_out", v), 64'(reg_ir_out), 64'(tbl[v].op));
            drive(CDR, 1'b0);
            chk($sformatf("tbl%0d_mode", v), 64'(reg_mode_bsc), 64'(tbl[v].mode));
            chk($sformatf("tbl%0d_cap_bsc", v), 64'(reg_capture_bsc), 64'(tbl[v].gate));
            edge1();
            drive(SDR, 1'b1);
            chk($sformatf("tbl%0d_tdo", v), 64'(reg_tdo), 64'(tbl[v].tdo));
            chk($sformatf("tbl%0d_sh_bsc", v),
                64'({reg_shift_bsc, reg_scan_to_bsc, reg_capture_bsc}),
                64'({tbl[v].gate, tbl[v].gate, 1'b0}));
            edge1();
            drive(UDR, 1'b0);
            chk($sformatf("tbl%0d_up_bsc", v), 64'(reg_update_bsc), 64'(tbl[v].gate));
            drive(6'b0, 1'b0);
        end

        // User 1 then user 0: capture, shift, update, one-cycle pulse
        user_scan(4'hB, 8'h5E, got);
        chk("u1_capture", 64'(got), 64'h81);
        chk("u1_out", 64'(user_dr_out), 64'h5E00);
        chk("u1_pulse", 64'(user_update_pulse), 64'h2);
        user_scan(4'hA, 8'hA5, got);
        chk("u0_capture", 64'(got), 64'h3C);
        chk("u0_out", 64'(user_dr_out), 64'h5EA5);
        chk("u0_pulse", 64'(user_update_pulse), 64'h1);
        edge1();
        chk("u0_pulse_drop", 64'(user_update_pulse), 64'h0);

        // EXTEST then Test-Logic-Reset
        load_ir(4'h3);
        chk("extest_mode", 64'(reg_mode_bsc), 64'h1);
        reg_test_logic_reset = 1'b1;
        edge1();
        reg_test_logic_reset = 1'b0;
        chk("tlr_mode", 64'(reg_mode_bsc), 64'h0);
        chk("tlr_ir_out", 64'(reg_ir_out), 64'h0);
        chk("tlr_user_out", 64'(user_dr_out), 64'h0);

        // Async reset mid-shift on user 1
        user_scan(4'hB, 8'h77, got);
        chk("u1_reload", 64'(user_dr_out), 64'h7700);
        drive(CDR, 1'b0); edge1();
        for (int i = 0; i < 3; i++) begin
            drive(SDR, 1'b1); edge1();
        end
        #2 reg_trstn = 1'b0;
        #1;
        chk("arst_user_out", 64'(user_dr_out), 64'h0);
        chk("arst_ir_out", 64'(reg_ir_out), 64'h0);
        drive(UDR, 1'b0);
        edge1();
        chk("arst_no_pulse", 64'(user_update_pulse), 64'h0);
        drive(6'b0, 1'b0);
        reg_trstn = 1'b1;
        edge1();

        // Clock enable low: flags have no effect, no pulse
        load_ir(4'hA);
        reg_tck_enable = 1'b0;
        load_ir(4'h3);
        chk("en0_ir_hold", 64'(reg_ir_out), 64'hA);
        drive(UDR, 1'b0); edge1();
        chk("en0_no_pulse", 64'(user_update_pulse), 64'h0);
        chk("en0_user_out", 64'(user_dr_out), 64'h0);
        drive(6'b0, 1'b0);
        reg_tck_enable = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/jtag_dr_bank.md
Name: jtag_dr_bank

Overview:
Parametrised JTAG instruction/data-register bank for the FPGA TAP. It sits between the TAP state controller and the boundary-scan chain and holds the IR (shift plus hold) and the IDCODE and BYPASS registers. It also gates the boundary-scan controls and adds NUM_USER user data registers. Each user register has a capture input, a parallel update output and a one-cycle update strobe. Unknown opcodes select BYPASS, as IEEE 1149.1 requires.

Parameters:
IR_LENGTH, 4, instruction register width (>=2)
IDCODE_VALUE, 32'h1A5B_C001, value captured for IDCODE; bit0 must be 1
IR_CAPTURE, 'b0101 (IR_LENGTH bits), value loaded on capture_ir; bits[1:0] must be 2'b01
NUM_USER, 2, number of user data registers (1..8)
USER_WIDTH, 8, width of each user data register (>=1)
USER_BASE, 'hA, opcode of user register 0; register k uses opcode USER_BASE+k

Ports:
internal_clk  in  1  system clock; all state updates on rising edge
reg_trstn  in  1  asynchronous, active-low reset
reg_tck_enable  in  1  qualifies every state update (one TCK event)
reg_test_logic_reset  in  1  TAP in Test-Logic-Reset
reg_capture_ir / reg_shift_ir / reg_update_ir  in  1 each  TAP IR phase flags
reg_capture_dr / reg_shift_dr / reg_update_dr  in  1 each  TAP DR phase flags
reg_tdi  in  1  serial data in
reg_tdo  out  1  serial data out (combinational mux)
reg_ir_out  out  IR_LENGTH  current held instruction
reg_mode_bsc  out  1  1 = BSC drives pins (EXTEST)
reg_capture_bsc / reg_shift_bsc / reg_update_bsc  out  1 each  gated DR controls to the BSC chain
reg_scan_to_bsc  out  1  TDI forwarded to the BSC chain
reg_scan_from_bsc  in  1  BSC chain serial out
user_dr_in  in  NUM_USER*USER_WIDTH  parallel capture values; register k uses slice [k*USER_WIDTH +: USER_WIDTH]
user_dr_out  out  NUM_USER*USER_WIDTH  parallel update values
user_update_pulse  out  NUM_USER  one-cycle strobe per register on update

Behaviour:
- Reset (reg_trstn low, async):
  - IR shift register and IR hold = IDCODE opcode (0).
  - IDCODE shift register = 0; bypass bit = 0.
  - All user shift registers = 0, user_dr_out = 0, user_update_pulse = 0.
- reg_test_logic_reset=1 with tck_enable=1 produces the same state as reset on the next edge.
- All non-reset updates require reg_tck_enable=1. With tck_enable=0, state holds and user_update_pulse = 0.
- Flag priority per register: test_logic_reset > capture > shift > update. Simultaneous flags therefore resolve by this priority.
- Opcodes:
  - IDCODE = 0, EXTEST = 3, SAMPLE = 8, BYPASS = all ones.
  - USER k = USER_BASE + k.
  - Any other value decodes as BYPASS.
  - Elaboration error if a user opcode collides with a fixed opcode or exceeds 2^IR_LENGTH-2.
- IR:
  - capture_ir loads IR_CAPTURE.
  - shift_ir does ir <= {tdi, ir[IR_LENGTH-1:1]} (LSB first).
  - update_ir loads hold from the shift register.
  - reg_ir_out = hold.
- DR operations act only on the register selected by hold; all other data registers keep their contents.
  - IDCODE: capture loads IDCODE_VALUE; shift is LSB-first, 32 bits.
  - BYPASS (including unknown opcodes): capture loads 0; shift loads tdi (1-bit delay).
  - USER k, capture: shift register <= user_dr_in slice k.
  - USER k, shift: sr <= {tdi, sr[USER_WIDTH-1:1]}.
  - USER k, update: slice k of user_dr_out <= sr, and user_update_pulse[k] = 1 for exactly one internal_clk cycle (registered). user_dr_out holds until the next update or reset.
- BSC gating (combinational):
  - For SAMPLE or EXTEST, the capture/shift/update BSC outputs follow the DR flags and reg_scan_to_bsc = tdi. Otherwise all four are 0.
  - reg_mode_bsc = 1 only when hold == EXTEST, so it drops immediately on reset.
- TDO mux (combinational):
  - shift_ir: ir[0].
  - Otherwise by hold: IDCODE -> idcode[0]; SAMPLE/EXTEST -> reg_scan_from_bsc; USER k -> sr_k[0]; BYPASS/unknown -> bypass bit.
- Latency:
  - TDI-to-TDO delay is N shifts, where N is the selected register length (1 for BYPASS).
  - Update takes effect on the output one clock after the update edge.
- Reset during a shift abandons the shift. user_dr_out clears to 0 and no pulse is issued.

Test Plan:
- Release reset, capture_dr, then 32 shifts with tdi=0 -> tdo sequence is LSBs of 32'h1A5B_C001 (first bit 1); reg_ir_out = 0.
- IR scan: capture_ir, then 4 shifts with tdi=1,1,1,1 -> tdo emits 1,0,1,0 (IR_CAPTURE LSB first); after update_ir, hold = 4'hF; DR shift of 1,0,1,1 appears on tdo delayed by one shift.
- Load opcode 4'h6 (unassigned) -> BYPASS behaviour (capture gives tdo=0, then 1-bit delay); all BSC controls stay 0.
- Load 4'hA, capture with user_dr_in[7:0]=8'h3C, shift in 8'hA5 -> tdo emits 0,0,1,1,1,1,0,0; after update_dr, user_dr_out[7:0] = 8'hA5, user_update_pulse = 2'b01 for one cycle, and user_dr_out[15:8] is unchanged.
- Load EXTEST (4'h3) -> reg_mode_bsc = 1 and BSC controls/scan_to_bsc mirror the DR flags/tdi; then assert test_logic_reset -> mode_bsc = 0 and hold = 0 on the next enabled edge.
- Mid-shift on USER 1, pulse reg_trstn low -> user_dr_out = 0, no update pulse, ir_out = 0; also toggle DR flags with tck_enable=0 -> no state change.
